// File: rtl/udma_hyper_ch_sched.sv
// Hyperbus channel scheduler: round-robin arbitration among NB_CH transfer channels,
// PHY issue handshake, and a programmable read/write recovery gap between transactions.
module udma_hyper_ch_sched #(
    parameter int NB_CH     = 4,
    parameter int CNT_WIDTH = 32,
    localparam int CH_W     = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NB_CH-1:0]     req_i,
    output logic [NB_CH-1:0]     gnt_o,
    output logic [NB_CH-1:0]     busy_vec_o,
    output logic                 phy_valid_o,
    input  logic                 phy_ready_i,
    output logic [CH_W-1:0]      phy_ch_o,
    input  logic                 done_i,
    input  logic [CNT_WIDTH-1:0] cfg_t_read_write_recovery_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACTIVE,
        RECOVER
    } state_e;

    state_e                 state_reg, state_next;
    logic [CH_W-1:0]        owner_reg, owner_next;
    logic [CH_W-1:0]        last_reg, last_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;

    logic [NB_CH-1:0]       req_hi;
    logic [CH_W-1:0]        hi_idx, lo_idx, winner;
    logic                   hi_vld, any_req;
    logic                   owns;

    // Requests strictly above the last-served index get first pick; otherwise wrap to 0.
    generate
        for (genvar gi = 0; gi < NB_CH; gi++) begin : g_mask
            assign req_hi[gi] = req_i[gi] && (CH_W'(gi) > last_reg);
        end
    endgenerate

    always_comb begin
        hi_idx  = '0;
        lo_idx  = '0;
        hi_vld  = 1'b0;
        any_req = 1'b0;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                hi_idx = CH_W'(i);
                hi_vld = 1'b1;
            end
            if (req_i[i]) begin
                lo_idx  = CH_W'(i);
                any_req = 1'b1;
            end
        end
        winner = hi_vld ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            last_reg  <= CH_W'(NB_CH - 1);
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    owner_next = winner;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // A handshake in the same cycle as a withdrawal still commits the transfer.
                if (phy_ready_i) begin
                    state_next = ACTIVE;
                    last_next  = owner_reg;
                end else if (!req_i[owner_reg]) begin
                    state_next = IDLE;
                end
            end
            ACTIVE: begin
                if (done_i) begin
                    cnt_next   = cfg_t_read_write_recovery_i;
                    state_next = (cfg_t_read_write_recovery_i != '0) ? RECOVER : IDLE;
                end
            end
            RECOVER: begin
                cnt_next = (cnt_reg != '0) ? cnt_reg - 1'b1 : '0;
                if (cnt_reg <= CNT_WIDTH'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign owns        = (state_reg == ISSUE) || (state_reg == ACTIVE);
    assign phy_valid_o = (state_reg == ISSUE);
    assign phy_ch_o    = owns ? owner_reg : '0;
    assign busy_vec_o  = gnt_o;

    generate
        for (genvar gi = 0; gi < NB_CH; gi++) begin : g_gnt
            assign gnt_o[gi] = owns && (owner_reg == CH_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_udma_hyper_ch_sched.sv
// Directed bench for udma_hyper_ch_sched with a handshake scoreboard of expected channels.
module tb_udma_hyper_ch_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  busy;
    logic        phy_valid;
    logic        phy_ready;
    logic [1:0]  phy_ch;
    logic        done;
    logic [31:0] cfg;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_q[$];
    int cyc;
    int rr_seq[5] = '{0, 1, 2, 3, 0};

    udma_hyper_ch_sched #(.NB_CH(4), .CNT_WIDTH(32)) dut (
        .clk_i                       (clk),
        .rst_ni                      (rst_n),
        .req_i                       (req),
        .gnt_o                       (gnt),
        .busy_vec_o                  (busy),
        .phy_valid_o                 (phy_valid),
        .phy_ready_i                 (phy_ready),
        .phy_ch_o                    (phy_ch),
        .done_i                      (done),
        .cfg_t_read_write_recovery_i (cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (phy_valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        chk("valid_up", 32'(phy_valid), 32'd1);
    endtask

    // Handshake, then end the transfer with done; request is dropped while ACTIVE.
    task automatic finish_txn();
        phy_ready = 1'b1;
        tick();
        phy_ready = 1'b0;
        req = 4'b0000;
        chk("fin_active_valid", 32'(phy_valid), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("fin_done_gnt", 32'(gnt), 32'd0);
    endtask

    // Scoreboard side: every PHY handshake must match the next expected owner.
    always @(negedge clk) begin
        int e;
        if (rst_n) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("busy_eq_gnt", 32'(busy), 32'(gnt));
            if (phy_valid && phy_ready) begin
                if (exp_q.size() == 0) begin
                    chk("hs_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("hs_ch", 32'(phy_ch), 32'(e));
                    chk("hs_gnt", 32'(gnt), 32'(1 << e));
                    $display("handshake ch=%0d gnt=%b", phy_ch, gnt);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; phy_ready = 1'b0; done = 1'b0; cfg = 32'd2;
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(phy_valid), 32'd0);
        chk("rst_ch", 32'(phy_ch), 32'd0);
        tick();
        rst_n = 1'b1;

        // All four channels requesting, recovery of 2 cycles
        req = 4'hF; phy_ready = 1'b1; cfg = 32'd2;
        for (int k = 0; k < 5; k++) exp_q.push_back(rr_seq[k]);
        for (int k = 0; k < 5; k++) begin
            wait_valid(cyc);
            if (k > 0) chk("rr_gap", 32'(cyc), 32'd3);
            chk("rr_gnt", 32'(gnt), 32'(1 << rr_seq[k]));
            chk("rr_ch", 32'(phy_ch), 32'(rr_seq[k]));
            tick();
            chk("rr_active_valid", 32'(phy_valid), 32'd0);
            chk("rr_active_gnt", 32'(gnt), 32'(1 << rr_seq[k]));
            tick();
            tick();
            done = 1'b1;
            if (k == 4) req = 4'b0000;
            tick();
            done = 1'b0;
            chk("rr_done_gnt", 32'(gnt), 32'd0);
        end
        phy_ready = 1'b0;
        tick(); tick(); tick();

        // Spurious done/ready in IDLE
        done = 1'b1; phy_ready = 1'b1;
        tick();
        done = 1'b0; phy_ready = 1'b0;
        chk("idle_spur_valid", 32'(phy_valid), 32'd0);
        chk("idle_spur_gnt", 32'(gnt), 32'd0);
        chk("idle_spur_ch", 32'(phy_ch), 32'd0);
        tick();
        chk("idle_spur_valid2", 32'(phy_valid), 32'd0);

        // Recovery of 4 with spurious pulses and a cfg write mid-RECOVER
        cfg = 32'd4; req = 4'b0010; exp_q.push_back(1);
        wait_valid(cyc);
        chk("rec_owner", 32'(phy_ch), 32'd1);
        phy_ready = 1'b1; tick(); phy_ready = 1'b0;
        tick();
        done = 1'b1; tick(); done = 1'b0;
        cfg = 32'd0; done = 1'b1; phy_ready = 1'b1; req = 4'b0100; exp_q.push_back(2);
        tick();
        done = 1'b0; phy_ready = 1'b0;
        chk("rec_spur_valid", 32'(phy_valid), 32'd0);
        chk("rec_spur_gnt", 32'(gnt), 32'd0);
        wait_valid(cyc);
        chk("rec_len", 32'(cyc), 32'd4);
        chk("rec_next_ch", 32'(phy_ch), 32'd2);

        // Zero recovery: pending request issues one cycle after done
        phy_ready = 1'b1; tick(); phy_ready = 1'b0;
        done = 1'b1; req = 4'b1000; exp_q.push_back(3);
        tick();
        done = 1'b0;
        chk("zero_rec_gnt", 32'(gnt), 32'd0);
        wait_valid(cyc);
        chk("zero_rec_lat", 32'(cyc), 32'd1);
        chk("zero_rec_ch", 32'(phy_ch), 32'd3);
        finish_txn();

        // Wrap-around from last-served 2
        req = 4'b0100; exp_q.push_back(2);
        wait_valid(cyc);
        finish_txn();
        req = 4'b0011; exp_q.push_back(0); exp_q.push_back(1);
        wait_valid(cyc);
        chk("wrap_first", 32'(phy_ch), 32'd0);
        phy_ready = 1'b1; tick(); phy_ready = 1'b0;
        done = 1'b1; tick(); done = 1'b0;
        wait_valid(cyc);
        chk("wrap_second", 32'(phy_ch), 32'd1);
        finish_txn();

        // Withdraw: last-served stays at ch0
        req = 4'b0001; exp_q.push_back(0);
        wait_valid(cyc);
        finish_txn();
        req = 4'b0010;
        wait_valid(cyc);
        chk("wd_issue_ch", 32'(phy_ch), 32'd1);
        req = 4'b0000;
        tick();
        chk("wd_idle_valid", 32'(phy_valid), 32'd0);
        chk("wd_idle_gnt", 32'(gnt), 32'd0);
        chk("wd_idle_ch", 32'(phy_ch), 32'd0);
        tick();
        chk("wd_no_recover", 32'(phy_valid), 32'd0);
        req = 4'b0110; exp_q.push_back(1);
        wait_valid(cyc);
        chk("wd_last_kept", 32'(phy_ch), 32'd1);

        // Drop request in the handshake cycle: handshake wins
        req = 4'b0000; phy_ready = 1'b1;
        tick();
        phy_ready = 1'b0;
        chk("drop_hs_gnt", 32'(gnt), 32'b0010);
        chk("drop_hs_valid", 32'(phy_valid), 32'd0);
        done = 1'b1; tick(); done = 1'b0;

        // Asynchronous reset while ch2 is ACTIVE
        req = 4'b0100; exp_q.push_back(2);
        wait_valid(cyc);
        phy_ready = 1'b1; tick(); phy_ready = 1'b0; req = 4'b0000;
        chk("pre_rst_gnt", 32'(gnt), 32'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(phy_valid), 32'd0);
        chk("arst_ch", 32'(phy_ch), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        chk("post_rst_gnt", 32'(gnt), 32'd0);
        req = 4'b1100; exp_q.push_back(2); exp_q.push_back(3);
        wait_valid(cyc);
        chk("post_rst_first", 32'(phy_ch), 32'd2);
        phy_ready = 1'b1; tick(); phy_ready = 1'b0;
        done = 1'b1; tick(); done = 1'b0;
        wait_valid(cyc);
        chk("post_rst_second", 32'(phy_ch), 32'd3);
        finish_txn();

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
